// File: rtl/piso_left.sv
// Parallel-in, serial-out shift-left transmitter, MSB first.
// A one-entry holding register lets the next word queue during a shift so words stream gap-free.
module piso_left #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [WIDTH-1:0] din,
  input  logic             load_vld,
  output logic             load_rdy,
  output logic             out,
  output logic             out_vld,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             accept;
  logic             last_bit;
  logic             bypass;

  assign load_rdy = !rst && !hold_full_q;
  assign accept   = load_vld && load_rdy;
  assign out_vld  = (state_q == StShift);
  assign out      = out_vld & sreg_q[WIDTH-1];
  assign last_bit = out_vld && enb && (cnt_q == '0);
  assign done     = last_bit;
  // An empty holding register plus an accept on the boundary edge loads the shifter directly.
  assign bypass   = last_bit && !hold_full_q && accept;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sreg_d  = din;
          cnt_d   = CntMax;
          state_d = StShift;
        end
      end
      StShift: begin
        if (enb) begin
          if (cnt_q == '0) begin
            if (hold_full_q) begin
              sreg_d      = hold_q;
              cnt_d       = CntMax;
              hold_full_d = 1'b0;
            end else if (accept) begin
              sreg_d = din;
              cnt_d  = CntMax;
            end else begin
              state_d = StIdle;
            end
          end else begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q - 1'b1;
          end
        end
        if (accept && !bypass) begin
          hold_d      = din;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_left.sv
// Self-checking bench for piso_left: word-queue reference model compared every cycle,
// plus a bench-side serial receiver that pins the model with literal expected words.
module tb_piso_left;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         enb;
  logic [W-1:0] din;
  logic         load_vld;
  logic         load_rdy;
  logic         out;
  logic         out_vld;
  logic         done;

  piso_left #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .din      (din),
    .load_vld (load_vld),
    .load_rdy (load_rdy),
    .out      (out),
    .out_vld  (out_vld),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted words (head is on the wire) and bit index in the head.
  logic [W-1:0] mq[$];
  int           midx = 0;
  bit           m_acc = 0;
  bit           started = 0;
  int           cyc = 0;

  initial forever begin
    bit rdy;
    @(posedge clk);
    started = 1;
    cyc++;
    m_acc = 0;
    if (rst) begin
      mq.delete();
      midx = 0;
    end else begin
      rdy = (mq.size() < 2);
      if (mq.size() > 0 && enb) begin
        if (midx == W - 1) begin
          void'(mq.pop_front());
          midx = 0;
        end else begin
          midx++;
        end
      end
      if (load_vld && rdy) begin
        mq.push_back(din);
        m_acc = 1;
      end
    end
  end

  // Compare DUT outputs with the model away from the active edge.
  initial forever begin
    logic [W-1:0] cur;
    logic         ev, eo, ed, er;
    @(negedge clk);
    if (started) begin
      ev  = (mq.size() > 0);
      cur = ev ? mq[0] : '0;
      eo  = ev ? cur[W-1-midx] : 1'b0;
      ed  = ev && enb && (midx == W - 1);
      er  = !rst && (mq.size() < 2);
      check("out_vld", {31'b0, out_vld}, {31'b0, ev});
      check("out", {31'b0, out}, {31'b0, eo});
      check("done", {31'b0, done}, {31'b0, ed});
      check("load_rdy", {31'b0, load_rdy}, {31'b0, er});
    end
  end

  // Bench-side serial receiver sharing enb: reassembles words at each done pulse.
  logic [W-1:0] rx_sh = '0;
  logic [W-1:0] rxq[$];
  int           done_cyc[$];

  initial forever begin
    logic [W-1:0] w;
    @(posedge clk);
    if (!rst && enb && out_vld) begin
      w     = {rx_sh[W-2:0], out};
      rx_sh = w;
      if (done) begin
        rxq.push_back(w);
        done_cyc.push_back(cyc);
      end
    end
  end

  bit rand_enb = 0;

  task automatic tick();
    if (rand_enb) enb = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] word);
    bit got;
    got      = 0;
    load_vld = 1'b1;
    din      = word;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      got = m_acc;
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
    load_vld = 1'b0;
  endtask

  initial begin
    bit pat[7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    rst = 1'b1; enb = 1'b1; load_vld = 1'b1; din = 4'b1010;

    // Reset with load_vld asserted: nothing accepted
    repeat (2) tick();
    check("rst_rdy", {31'b0, load_rdy}, 32'd0);
    check("rst_vld", {31'b0, out_vld}, 32'd0);
    rst = 1'b0; load_vld = 1'b0;
    #1;
    check("post_rst_rdy", {31'b0, load_rdy}, 32'd1);
    tick();
    check("post_rst_idle", {31'b0, out_vld}, 32'd0);

    // Single word, continuous enable
    rxq.delete(); done_cyc.delete();
    enb = 1'b1;
    send(4'b1011);
    repeat (6) tick();
    check("single_cnt", rxq.size(), 32'd1);
    if (rxq.size() > 0) check("single_word", {28'b0, rxq[0]}, 32'hb);
    check("single_done", done_cyc.size(), 32'd1);

    // Enable gaps
    rxq.delete();
    enb = 1'b0;
    send(4'b1001);
    foreach (pat[i]) begin
      enb = pat[i];
      tick();
    end
    enb = 1'b0;
    repeat (2) tick();
    check("gap_cnt", rxq.size(), 32'd1);
    if (rxq.size() > 0) check("gap_word", {28'b0, rxq[0]}, 32'h9);

    // Back-to-back through the holding register
    rxq.delete(); done_cyc.delete();
    enb = 1'b1;
    send(4'b1011);
    tick();
    send(4'b0110);
    check("b2b_rdy_low", {31'b0, load_rdy}, 32'd0);
    repeat (10) tick();
    check("b2b_cnt", rxq.size(), 32'd2);
    if (rxq.size() > 1) begin
      check("b2b_w0", {28'b0, rxq[0]}, 32'hb);
      check("b2b_w1", {28'b0, rxq[1]}, 32'h6);
    end
    if (done_cyc.size() > 1) check("b2b_spacing", done_cyc[1] - done_cyc[0], 32'd4);

    // Reset mid-word with a queued word
    enb = 1'b0;
    send(4'b1111);
    send(4'b0001);
    enb = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("midrst_vld", {31'b0, out_vld}, 32'd0);
    check("midrst_rdy", {31'b0, load_rdy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    tick();
    rst = 1'b0;
    rxq.delete();
    repeat (8) tick();
    check("midrst_residual", rxq.size(), 32'd0);
    check("midrst_idle", {31'b0, out_vld}, 32'd0);

    // Loopback of all 16 words under random enable
    rxq.delete();
    rand_enb = 1;
    for (int w = 0; w < 16; w++) send(W'(w));
    rand_enb = 0;
    enb = 1'b1;
    repeat (12) tick();
    check("loop_cnt", rxq.size(), 32'd16);
    for (int i = 0; i < 16 && i < rxq.size(); i++) check("loop_word", {28'b0, rxq[i]}, i);

    // Random traffic with sporadic resets
    rand_enb = 1;
    for (int i = 0; i < 400; i++) begin
      load_vld = ($urandom_range(0, 1) != 0);
      din      = W'($urandom);
      rst      = ($urandom_range(0, 63) == 0);
      tick();
    end
    rand_enb = 0;
    rst = 1'b0; load_vld = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
